pipe_hazard_ctrl: RTL and testbench

Central stall/flush/forward controller for the five-stage MIPS pipeline. It drives the per-stage `Stall*`/`Flush*` inputs of the F/D/E/M/W pipeline registers and the forwarding-mux selects for the D and E stages. It also sequences the multi-cycle multiply/divide unit (MDU) through a busy-counter state machine that holds the E stage for the operation's latency. It sits beside the datapath and owns no datapath state other than the MDU sequencer.

---
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the five-stage MIPS pipeline, plus the MDU busy sequencer.
// Define PIPE_MDU_MULTICYCLE_EN to build the multi-cycle MDU sequencer; otherwise the MDU is single-cycle.
module pipe_hazard_ctrl #(
   parameter int MULT_LAT = 2,
   parameter int DIV_LAT  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic       BranchD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic       RegWriteE,
   input  logic       MemtoRegE,
   input  logic       MduOpE,
   input  logic       MduDivE,
   input  logic [4:0] WriteRegM,
   input  logic       RegWriteM,
   input  logic       MemtoRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteW,
   input  logic       i_req,
   input  logic       i_data_ok,
   input  logic       d_req,
   input  logic       d_data_ok,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic       FlushW,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       mdu_go,
   output logic       mdu_busy
);

   logic dWait_s, iWait_s, lwStall_s, brStall_s, mduHold_s;

   function automatic logic [1:0] fwdSelE(input logic [4:0] src, input logic [4:0] wrM, input logic rwM,
                                          input logic [4:0] wrW, input logic rwW);
      logic [1:0] sel;
      if (rwM & (wrM == src) & (src != 5'd0)) sel = 2'b10;
      else if (rwW & (wrW == src) & (src != 5'd0)) sel = 2'b01;
      else sel = 2'b00;
      return sel;
   endfunction

   // Hazard terms; index 0 is hard-wired zero and never creates a dependency
   always_comb begin
      dWait_s   = d_req & ~d_data_ok;
      iWait_s   = i_req & ~i_data_ok;
      lwStall_s = MemtoRegE & (WriteRegE != 5'd0) & ((WriteRegE == RsD) | (WriteRegE == RtD));
      brStall_s = BranchD &
                  ((RegWriteE & (WriteRegE != 5'd0) & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                   (MemtoRegM & (WriteRegM != 5'd0) & ((WriteRegM == RsD) | (WriteRegM == RtD))));
   end

   // Prioritised stall/flush selection: only the strongest active source applies
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      FlushW = 1'b0;
      if (dWait_s) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (mduHold_s) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushM = 1'b1;
      end else if (lwStall_s | brStall_s) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end else if (iWait_s) begin
         StallF = 1'b1;
         FlushD = 1'b1;
      end else begin
         StallF = 1'b0;
      end
   end

   // Forwarding selects, independent of stalls
   always_comb begin
      ForwardAD = RegWriteM & (WriteRegM == RsD) & (RsD != 5'd0);
      ForwardBD = RegWriteM & (WriteRegM == RtD) & (RtD != 5'd0);
      ForwardAE = fwdSelE(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      ForwardBE = fwdSelE(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
   end

`ifdef PIPE_MDU_MULTICYCLE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mduState_t;
   localparam logic [5:0] MULT_LAT_C = 6'(MULT_LAT);
   localparam logic [5:0] DIV_LAT_C  = 6'(DIV_LAT);

   mduState_t  state_r, stateNext_s;
   logic [5:0] cnt_r, cntNext_s, lat_s;
   logic       go_s;

   // Sequencer state and busy counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 6'd0;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
      end
   end

   // Next state; DONE waits for the op to leave E so a held op is not re-issued
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      go_s        = 1'b0;
      lat_s       = MduDivE ? DIV_LAT_C : MULT_LAT_C;
      case (state_r)
         IDLE: begin
            if (MduOpE & ~dWait_s) begin
               go_s = 1'b1;
               if (lat_s == 6'd1) begin
                  stateNext_s = DONE;
               end else begin
                  stateNext_s = BUSY;
                  cntNext_s   = lat_s - 6'd1;
               end
            end else begin
               stateNext_s = IDLE;
            end
         end
         BUSY: begin
            cntNext_s = cnt_r - 6'd1;
            if (cnt_r == 6'd1) stateNext_s = DONE;
            else stateNext_s = BUSY;
         end
         DONE: begin
            if (~StallE) stateNext_s = IDLE;
            else stateNext_s = DONE;
         end
         default: begin
            stateNext_s = IDLE;
            cntNext_s   = 6'd0;
         end
      endcase
   end

   // MDU hold and status outputs
   always_comb begin
      mduHold_s = (state_r == BUSY) | ((state_r == IDLE) & MduOpE);
      mdu_go    = go_s;
      mdu_busy  = (state_r != IDLE);
   end
`else
   logic unusedSig_s;

   // Single-cycle MDU: launch whenever the op is allowed to move through E
   always_comb begin
      mduHold_s   = 1'b0;
      mdu_go      = MduOpE & ~StallE;
      mdu_busy    = 1'b0;
      unusedSig_s = ^{clk, reset, MduDivE, 6'(MULT_LAT), 6'(DIV_LAT)};
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, plus MDU sequencer sequences when
// PIPE_MDU_MULTICYCLE_EN is defined.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       BranchD, RegWriteE, MemtoRegE, MduOpE, MduDivE;
   logic       RegWriteM, MemtoRegM, RegWriteW;
   logic       i_req, i_data_ok, d_req, d_data_ok;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
   logic       ForwardAD, ForwardBD, mdu_go, mdu_busy;
   logic [1:0] ForwardAE, ForwardBE;

   int nVec = 0;
   int nErr = 0;

   typedef struct {
      string      name;
      logic [4:0] rsD, rtD;
      logic       br;
      logic [4:0] rsE, rtE, wrE;
      logic       rwE, mrE;
      logic [4:0] wrM;
      logic       rwM, mrM;
      logic [4:0] wrW;
      logic       rwW;
      logic [3:0] mem;   // {i_req, i_data_ok, d_req, d_data_ok}
      logic       op;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   pipe_hazard_ctrl #(.MULT_LAT(2), .DIV_LAT(32)) dut (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
      .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .MduOpE(MduOpE), .MduDivE(MduDivE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
      .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .i_req(i_req), .i_data_ok(i_data_ok), .d_req(d_req), .d_data_ok(d_data_ok),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mdu_go(mdu_go), .mdu_busy(mdu_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pk(input logic [3:0] st, input logic [3:0] fl, input logic [1:0] fd,
                                      input logic [1:0] fae, input logic [1:0] fbe, input logic go,
                                      input logic busy);
      return {st, fl, fd, fae, fbe, go, busy};
   endfunction

   function automatic vec_t mk(input string name, input logic [4:0] rsD, input logic [4:0] rtD,
                               input logic br, input logic [4:0] rsE, input logic [4:0] rtE,
                               input logic [4:0] wrE, input logic rwE, input logic mrE,
                               input logic [4:0] wrM, input logic rwM, input logic mrM,
                               input logic [4:0] wrW, input logic rwW, input logic [3:0] mem,
                               input logic op, input logic [15:0] exp);
      vec_t v;
      v.name = name; v.rsD = rsD; v.rtD = rtD; v.br = br; v.rsE = rsE; v.rtE = rtE;
      v.wrE = wrE; v.rwE = rwE; v.mrE = mrE; v.wrM = wrM; v.rwM = rwM; v.mrM = mrM;
      v.wrW = wrW; v.rwW = rwW; v.mem = mem; v.op = op; v.exp = exp;
      return v;
   endfunction

   function automatic logic [15:0] actual();
      return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
              ForwardAD, ForwardBD, ForwardAE, ForwardBE, mdu_go, mdu_busy};
   endfunction

   task automatic applyVec(input vec_t v);
      RsD = v.rsD; RtD = v.rtD; BranchD = v.br; RsE = v.rsE; RtE = v.rtE;
      WriteRegE = v.wrE; RegWriteE = v.rwE; MemtoRegE = v.mrE;
      WriteRegM = v.wrM; RegWriteM = v.rwM; MemtoRegM = v.mrM;
      WriteRegW = v.wrW; RegWriteW = v.rwW;
      {i_req, i_data_ok, d_req, d_data_ok} = v.mem;
      MduOpE = v.op; MduDivE = 1'b0;
   endtask

   task automatic chkOut(input string name, input logic [15:0] exp);
      logic [15:0] act;
      act = actual();
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %b, expected %b (Stall FDEM Flush DEMW FwdD AE BE go busy)", name, act, exp);
      end
   endtask

   task automatic chkInt(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nErr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

`ifdef PIPE_MDU_MULTICYCLE_EN
   task automatic runMdu(input logic div, input int expLat, input string name);
      int   stalls, gos, leave;
      logic firstGo;
      stalls = 0; gos = 0; leave = 0; firstGo = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (leave == 0) begin
            @(negedge clk);
            MduOpE = 1'b1; MduDivE = div;
            #1;
            if (mdu_go) gos++;
            if (c == 1) firstGo = mdu_go;
            if (StallE) stalls++;
            else leave = c;
         end
      end
      chkInt({name, "_go_first_cycle"}, int'(firstGo), 1);
      chkInt({name, "_go_pulses"}, gos, 1);
      chkInt({name, "_stallE_cycles"}, stalls, expLat);
      chkInt({name, "_leave_cycle"}, leave, expLat + 1);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t base;
      base = mk("base", 5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0,
                4'b0000, 1'b0, 16'd0);

      //          name                rsD    rtD   br    rsE    rtE    wrE   rwE   mrE   wrM    rwM   mrM   wrW    rwW   mem      op    expected
      vecs.push_back(mk("idle",         5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("lw_rs",        5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b1100, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("lw_rt",        5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b1100, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("lw_zero",      5'd0, 5'd2, 1'b0, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("lw_nomatch",   5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("alu_no_branch",5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("br_dep_E",     5'd1, 5'd2, 1'b1, 5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b1100, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("br_load_M",    5'd1, 5'd2, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b1100, 4'b0100, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("br_fwdAD",     5'd1, 5'd2, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("fwdBD",        5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("br_zero",      5'd0, 5'd0, 1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("fwdE_M",       5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("fwdE_W",       5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd4, 1'b1, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0)));
      vecs.push_back(mk("fwdE_M_over_W",5'd1, 5'd2, 1'b0, 5'd3, 5'd3, 5'd5, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0)));
      vecs.push_back(mk("fwdE_W_noRwM", 5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("fwdE_zero",    5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("iwait",        5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b1000, 1'b0, pk(4'b1000, 4'b1000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("iwait_ok",     5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b1100, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("dwait",        5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0010, 1'b0, pk(4'b1111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("dwait_ok",     5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0011, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("lw_over_iwait",5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b1000, 1'b0, pk(4'b1100, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("dwait_over_lw",5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0010, 1'b0, pk(4'b1111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("dwait_over_iw",5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b1010, 1'b0, pk(4'b1111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("fwd_in_dwait", 5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd7, 1'b0, 4'b0010, 1'b0, pk(4'b1111, 4'b0001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("load_t0_c1",   5'd8, 5'd2, 1'b0, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b1100, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
      vecs.push_back(mk("load_t0_c2",   5'd1, 5'd2, 1'b0, 5'd8, 5'd4, 5'd5, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd7, 1'b0, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0)));
`ifndef PIPE_MDU_MULTICYCLE_EN
      vecs.push_back(mk("mdu_go_1cyc",  5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0000, 1'b1, pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0)));
      vecs.push_back(mk("mdu_go_dwait", 5'd1, 5'd2, 1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0, 4'b0010, 1'b1, pk(4'b1111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0)));
`endif

      applyVec(base);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chkOut("reset_state", pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyVec(vecs[i]);
         #1;
         chkOut(vecs[i].name, vecs[i].exp);
      end

`ifdef PIPE_MDU_MULTICYCLE_EN
      // DIV then back-to-back MULT
      @(negedge clk);
      applyVec(base);
      runMdu(1'b1, 32, "div");
      runMdu(1'b0, 2, "mult_b2b");
      @(negedge clk);
      MduOpE = 1'b0;
      #1;
      chkOut("mdu_back_idle", pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

      // MULT with a data-memory wait starting in its BUSY cycle
      @(negedge clk);
      MduOpE = 1'b1; MduDivE = 1'b0;
      #1;
      chkOut("mul_issue", pk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         d_req = 1'b1; d_data_ok = 1'b0;
         #1;
         chkOut((c == 0) ? "mul_busy_dwait" : "mul_done_dwait",
                pk(4'b1111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
      end
      @(negedge clk);
      d_data_ok = 1'b1;
      #1;
      chkOut("mul_done_release", pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
      @(negedge clk);
      d_req = 1'b0; d_data_ok = 1'b0; MduOpE = 1'b0;
      #1;
      chkOut("mul_after_idle", pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

      // Reset in the 10th BUSY cycle of a DIV
      @(negedge clk);
      MduOpE = 1'b1; MduDivE = 1'b1;
      #1;
      chkOut("div_rst_issue", pk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
      for (int c = 2; c <= 11; c++) begin
         @(negedge clk);
         #1;
         if (c == 11) begin
            chkOut("div_busy10", pk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
            reset = 1'b1;
         end
      end
      @(negedge clk);
      reset = 1'b0; MduOpE = 1'b0;
      #1;
      chkOut("div_after_reset", pk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
